// File: rtl/datapath_wall.sv
// Wall datapath: decodes wall state codes, owns the wall position and sweeps
// erase / move / draw pixel jobs to the VGA adapter; flags collisions.
module datapath_wall #(
   parameter int         X_START   = 156,
   parameter int         Y_TOP     = 40,
   parameter int         WALL_W    = 4,
   parameter int         WALL_H    = 40,
   parameter int         PLAYER_SZ = 8,
   parameter int         STEP      = 1,
   parameter int         TICK_DIV  = 833333,
   parameter logic [2:0] COLOUR    = 3'b111
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic [3:0] state,
   input  logic [7:0] player_x,
   input  logic [6:0] player_y,
   output logic [7:0] x,
   output logic [6:0] y,
   output logic [2:0] colour,
   output logic       plot,
   output logic       touched,
   output logic [7:0] wall_x
);

   localparam logic [3:0] ST_READY = 4'b0101;
   localparam logic [3:0] ST_MOVE  = 4'b0110;
   localparam logic [3:0] ST_STOP  = 4'b0111;
   localparam logic [3:0] ST_DEL   = 4'b1001;
   localparam int         TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   typedef enum logic [1:0] {E_IDLE, E_ERASE, E_MOVE, E_DRAW} eng_t;

   eng_t          eng;
   logic [TW-1:0] tick_cnt;
   logic          tick_wrap;
   logic          pending;
   logic          armed;
   logic          start;
   logic [4:0]    col;
   logic [6:0]    row;
   logic [4:0]    col_n;
   logic [6:0]    row_n;
   logic          last_px;
   logic [8:0]    wx9;
   logic [8:0]    px9;
   logic [8:0]    py9;
   logic          hit;

   function automatic logic [7:0] step_sat(input logic [7:0] w);
      return (w < 8'(STEP)) ? 8'd0 : w - 8'(STEP);
   endfunction

   assign tick_wrap = (tick_cnt == TW'(TICK_DIV - 1));
   assign start     = (eng == E_IDLE) && (state == ST_DEL) && armed && pending;
   assign last_px   = (col == 5'(WALL_W - 1)) && (row == 7'(WALL_H - 1));
   assign col_n     = (col == 5'(WALL_W - 1)) ? 5'd0 : col + 5'd1;
   assign row_n     = (col == 5'(WALL_W - 1)) ? row + 7'd1 : row;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         tick_cnt <= '0;
         armed    <= 1'b0;
         pending  <= 1'b0;
      end else begin
         tick_cnt <= tick_wrap ? '0 : tick_cnt + TW'(1);
         if (state == ST_MOVE)
            armed <= 1'b1;
         else if (state == ST_STOP || state == ST_READY)
            armed <= 1'b0;
         // A fresh tick wins over a clear, so a tick landing on job start is kept
         if (tick_wrap)
            pending <= 1'b1;
         else if (start || (eng == E_IDLE && state == ST_READY))
            pending <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         eng    <= E_IDLE;
         wall_x <= 8'(X_START);
         col    <= '0;
         row    <= '0;
         x      <= '0;
         y      <= '0;
         colour <= '0;
         plot   <= 1'b0;
      end else begin
         case (eng)
            E_IDLE: begin
               if (start) begin
                  eng    <= E_ERASE;
                  col    <= '0;
                  row    <= '0;
                  x      <= wall_x;
                  y      <= 7'(Y_TOP);
                  colour <= 3'b000;
                  plot   <= 1'b1;
               end else if (state == ST_READY) begin
                  wall_x <= 8'(X_START);
               end
            end
            E_ERASE: begin
               if (last_px) begin
                  eng  <= E_MOVE;
                  plot <= 1'b0;
               end else begin
                  col <= col_n;
                  row <= row_n;
                  x   <= wall_x + 8'(col_n);
                  y   <= 7'(Y_TOP) + row_n;
               end
            end
            // Output registers load the first draw pixel from the stepped position
            E_MOVE: begin
               wall_x <= step_sat(wall_x);
               eng    <= E_DRAW;
               col    <= '0;
               row    <= '0;
               x      <= step_sat(wall_x);
               y      <= 7'(Y_TOP);
               colour <= COLOUR;
               plot   <= 1'b1;
            end
            E_DRAW: begin
               if (last_px) begin
                  eng  <= E_IDLE;
                  plot <= 1'b0;
               end else begin
                  col <= col_n;
                  row <= row_n;
                  x   <= wall_x + 8'(col_n);
                  y   <= 7'(Y_TOP) + row_n;
               end
            end
            default: eng <= E_IDLE;
         endcase
      end
   end

   // Widened to 9 bits so player_x + PLAYER_SZ - 1 never wraps
   assign wx9 = {1'b0, wall_x};
   assign px9 = {1'b0, player_x};
   assign py9 = {2'b00, player_y};
   assign hit = (wall_x == 8'd0) ||
                ((wx9 <= px9 + 9'(PLAYER_SZ - 1)) &&
                 (px9 <= wx9 + 9'(WALL_W - 1)) &&
                 (9'(Y_TOP) <= py9 + 9'(PLAYER_SZ - 1)) &&
                 (py9 <= 9'(Y_TOP + WALL_H - 1)));

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         touched <= 1'b0;
      else
         touched <= hit;
   end

endmodule

// File: tb/tb_datapath_wall.sv
// Bench for datapath_wall: random player positions and repeated wall jobs
// checked against a pixel-list / position model of the wall.
module tb_datapath_wall;

   localparam int W   = 2;
   localparam int H   = 3;
   localparam int YT  = 40;
   localparam int XS  = 156;
   localparam int XS2 = 5;

   localparam logic [3:0] ST_READY = 4'b0101;
   localparam logic [3:0] ST_MOVE  = 4'b0110;
   localparam logic [3:0] ST_STOP  = 4'b0111;
   localparam logic [3:0] ST_DRAW  = 4'b1000;
   localparam logic [3:0] ST_DEL   = 4'b1001;
   localparam logic [3:0] ST_UPD   = 4'b1010;

   logic       clk = 1'b0;
   logic       resetn;
   logic [3:0] state;
   logic [7:0] player_x, player_x2;
   logic [6:0] player_y, player_y2;
   logic [7:0] x, x2, wall_x, wall_x2;
   logic [6:0] y, y2;
   logic [2:0] colour, colour2;
   logic       plot, plot2, touched, touched2;

   int checks = 0;
   int errors = 0;
   int m_wall, m_wall2;

   always #5 clk = ~clk;

   datapath_wall #(.X_START(XS), .Y_TOP(YT), .WALL_W(W), .WALL_H(H), .PLAYER_SZ(8),
                   .STEP(1), .TICK_DIV(4), .COLOUR(3'b111)) dut (
      .clk(clk), .resetn(resetn), .state(state), .player_x(player_x), .player_y(player_y),
      .x(x), .y(y), .colour(colour), .plot(plot), .touched(touched), .wall_x(wall_x));

   datapath_wall #(.X_START(XS2), .Y_TOP(YT), .WALL_W(W), .WALL_H(H), .PLAYER_SZ(8),
                   .STEP(2), .TICK_DIV(4), .COLOUR(3'b111)) dut2 (
      .clk(clk), .resetn(resetn), .state(state), .player_x(player_x2), .player_y(player_y2),
      .x(x2), .y(y2), .colour(colour2), .plot(plot2), .touched(touched2), .wall_x(wall_x2));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int exp_touch(input int w, input int px, input int py);
      return int'((w == 0) || (w <= px + 7 && px <= w + W - 1 && YT <= py + 7 && py <= YT + H - 1));
   endfunction

   task automatic check_touch(input string tag);
      chk({tag, "_touch"},  touched,  exp_touch(m_wall,  player_x,  player_y));
      chk({tag, "_touch2"}, touched2, exp_touch(m_wall2, player_x2, player_y2));
   endtask

   // One erase/move/draw job: erase list at the old x, one gap, draw list at the new x
   task automatic run_job(input string tag);
      int n;
      n = 0;
      state = ST_DEL;
      @(negedge clk);
      while (plot !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_start"}, plot, 1);
      if (plot === 1'b1) begin
         chk({tag, "_start2"}, plot2, 1);
         state = ST_UPD;
         for (int p = 0; p < 2*W*H + 1; p++) begin
            if (p > 0) @(negedge clk);
            if (p == W*H) begin
               chk({tag, "_gap"}, plot, 0);
               m_wall  = (m_wall  < 1) ? 0 : m_wall - 1;
               m_wall2 = (m_wall2 < 2) ? 0 : m_wall2 - 2;
            end else begin
               int q;
               q = (p < W*H) ? p : p - W*H - 1;
               chk({tag, "_plot"}, plot, 1);
               chk({tag, "_x"}, x, m_wall + q % W);
               chk({tag, "_y"}, y, YT + q / W);
               chk({tag, "_col"}, colour, (p < W*H) ? 0 : 7);
            end
         end
         @(negedge clk);
         chk({tag, "_end"}, plot, 0);
         chk({tag, "_wall"}, wall_x, m_wall);
         chk({tag, "_wall2"}, wall_x2, m_wall2);
         check_touch(tag);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int dx[8];
      int by[8];
      dx = '{-8, -7, W - 1, W, 0, 0, 0, 0};
      by = '{YT, YT, YT, YT, YT - 8, YT - 7, YT + H - 1, YT + H};
      resetn = 1'b0;
      state = ST_UPD;
      player_x = 8'd0;   player_y = 7'd0;
      player_x2 = 8'd100; player_y2 = 7'd100;
      m_wall = XS;
      m_wall2 = XS2;
      repeat (3) @(negedge clk);
      chk("rst_plot", plot, 0);
      chk("rst_x", x, 0);
      chk("rst_y", y, 0);
      chk("rst_colour", colour, 0);
      chk("rst_touch", touched, 0);
      chk("rst_wall", wall_x, XS);
      chk("rst_wall2", wall_x2, XS2);
      chk("rst_out2", {x2, y2, colour2}, 0);

      // Armed but no tick yet: DEL must not start a job
      resetn = 1'b1;
      state = ST_MOVE;
      @(negedge clk); chk("nopend_move", plot, 0);
      state = ST_DEL;
      @(negedge clk); chk("nopend_del", plot, 0);
      state = ST_UPD;
      @(negedge clk); chk("nopend_upd", plot, 0);
      state = ST_DRAW;
      @(negedge clk); chk("nopend_draw", plot, 0);

      run_job("job0");

      for (int i = 0; i < 8; i++) begin
         player_x = 8'($urandom_range(140, 165));
         player_y = 7'($urandom_range(28, 50));
         @(negedge clk);
         check_touch("rnd_pre");
         run_job("rnd_job");
      end

      for (int i = 0; i < 8; i++) begin
         player_x = 8'(m_wall + dx[i]);
         player_y = 7'(by[i]);
         @(negedge clk);
         chk("bound_touch", touched, exp_touch(m_wall, player_x, player_y));
      end

      state = ST_STOP;
      @(negedge clk);
      state = ST_DEL;
      repeat (12) begin
         @(negedge clk);
         chk("stop_plot", plot, 0);
      end
      chk("stop_wall", wall_x, m_wall);

      player_x = 8'd0;
      player_y = 7'd0;
      state = ST_UPD;
      @(negedge clk);
      chk("sat_touch2", touched2, exp_touch(m_wall2, player_x2, player_y2));
      state = ST_READY;
      @(negedge clk);
      state = ST_UPD;
      m_wall = XS;
      m_wall2 = XS2;
      @(negedge clk);
      chk("ready_wall", wall_x, XS);
      chk("ready_wall2", wall_x2, XS2);
      check_touch("ready");

      state = ST_MOVE;
      @(negedge clk);
      run_job("job_after_ready");

      player_x = 8'd150;
      player_y = 7'd40;
      state = ST_DEL;
      begin
         int n;
         n = 0;
         while (plot !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
         end
         chk("midrst_start", plot, 1);
      end
      repeat (2) @(negedge clk);
      resetn = 1'b0;
      #1;
      chk("midrst_plot", plot, 0);
      chk("midrst_wall", wall_x, XS);
      chk("midrst_touch", touched, 0);
      chk("midrst_wall2", wall_x2, XS2);
      state = ST_UPD;
      m_wall = XS;
      m_wall2 = XS2;
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      check_touch("post_rst");
      state = ST_MOVE;
      @(negedge clk);
      run_job("job_after_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
